// File: rtl/handshake_beat_tx.sv
// Word-to-beat transmitter: loads a WIDTH*BEATS word and sends it LSB beat first
// over a valid/ready channel, one beat per cycle when the receiver is ready.
module handshake_beat_tx #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [WIDTH*BEATS-1:0] word_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   last_o,
  input  logic                   ready_i
);
  localparam int WORD_W = WIDTH * BEATS;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [WORD_W-1:0] shreg, sh_n;
  logic [WIDTH-1:0]  data_n;
  logic              valid_n, busy_n, last_n, done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      last_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= sh_n;
      data_o  <= data_n;
      valid_o <= valid_n;
      busy_o  <= busy_n;
      last_o  <= last_n;
      done_o  <= done_n;
    end
  end

  // shreg holds the beats not yet presented; data_o is the beat on the wire
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = shreg;
    data_n  = data_o;
    valid_n = valid_o;
    busy_n  = busy_o;
    last_n  = last_o;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        last_n  = 1'b0;
        if (start_i) begin
          state_n = SEND;
          cnt_n   = '0;
          data_n  = word_i[WIDTH-1:0];
          sh_n    = word_i >> WIDTH;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          last_n  = (BEATS == 1);
        end
      end
      SEND: begin
        if (ready_i) begin
          if (cnt == LAST_CNT) begin
            state_n = IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            last_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            cnt_n  = cnt + CW'(1);
            data_n = shreg[WIDTH-1:0];
            sh_n   = shreg >> WIDTH;
            last_n = (cnt_n == LAST_CNT);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
